core_bus_arbiter: RTL and testbench
===================================

Name: core_bus_arbiter

Overview:
Sits directly downstream of the CPU core. It takes the core's instruction-bus request (ireq/iresp) and data-bus request (dreq/dresp), grants one at a time, and drives a single-beat transaction onto the shared cache bus (cbus). It returns addr_ok/data_ok/data to the requester that was granted. Only one transaction is outstanding at any time.

Parameters:
TIMEOUT_CYCLES, 1023, cycles waiting for a cbus response before timeout_err sets; 0 disables the check.

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
ireq_valid  in  1  instruction fetch request
ireq_addr  in  32  physical fetch address
iresp_addr_ok  out  1  fetch request accepted
iresp_data_ok  out  1  fetch data valid
iresp_data  out  32  fetch data
dreq_valid  in  1  data request
dreq_addr  in  32  physical data address
dreq_size  in  3  msize_t (MSIZE1/2/4)
dreq_strobe  in  4  byte write enables; 0 means read
dreq_data  in  32  write data
dresp_addr_ok  out  1  data request accepted
dresp_data_ok  out  1  data response valid
dresp_data  out  32  read data
creq_valid  out  1  cbus request valid
creq_is_write  out  1  write transaction
creq_size  out  3  transfer size
creq_addr  out  32  address
creq_strobe  out  4  byte enables
creq_data  out  32  write data
creq_len  out  4  burst length − 1; always 0
cresp_ready  in  1  beat complete
cresp_last  in  1  last beat
cresp_data  in  32  read data
timeout_err  out  1  sticky response-timeout flag

Behaviour:
- Reset is asynchronous and active-high. While reset is high and on its release: state=IDLE, latched request cleared, timeout counter=0, timeout_err=0, and every output is 0. Dropping creq_valid mid-transaction is permitted; the downstream side discards the transaction.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE grant rules:
  - dreq_valid=1: grant data, regardless of ireq_valid. Data has priority because the memory stage is older.
  - Else if ireq_valid=1: grant instruction.
  - The granted addr_ok is asserted combinationally in the same cycle. Request fields are latched at the clock edge and the state moves to the matching BUSY state.
  - addr_ok is never asserted outside IDLE. The ungranted requester keeps valid held and waits.
- Latched fields:
  - Instruction grant: is_write=0, size=MSIZE4, strobe=0, data=0.
  - Data grant: is_write=|dreq_strobe, size=dreq_size, strobe=dreq_strobe, data=dreq_data.
- BUSY_x:
  - creq_valid=1 and creq_* are driven from the registers. They stay stable until completion.
  - Completion is cresp_ready&cresp_last. On completion the matching data_ok=1 combinationally for one cycle, with data=cresp_data (write responses return the data unchanged). The next state is IDLE.
  - cresp_ready without cresp_last is treated as a protocol error: ignore it and stay in BUSY.
- Round-trip minimum: addr_ok in cycle 0, creq_valid from cycle 1, data_ok in cycle 1 if the response is immediate. A new grant can occur no earlier than the cycle after data_ok.
- Outputs in IDLE: creq_valid=0 and all creq_* fields=0. data_ok=0 in every state except the completion cycle. iresp_data and dresp_data are 0 whenever their data_ok is 0.
- Timeout:
  - The counter resets to 0 on every grant and increments each BUSY cycle without completion, saturating at its maximum.
  - When the counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0), timeout_err is set and stays set until reset.
  - The transaction keeps waiting after a timeout.
- Simultaneous events: if valid is dropped during BUSY, the transaction still completes and data_ok still pulses. In IDLE, if both requests are valid in consecutive cycles, the data request wins each time.

Decomposition:
- Shared package: msize_t, the state enum arb_state_t, the cbus_req_t/cbus_resp_t structs and the ibus/dbus request/response structs. The top level packs the flat ports into these structs.
- The timeout counter is one natural sub-module, bus_timeout_counter: inputs clear and busy, output a sticky expired flag.

Test Plan:
- Single fetch: ireq addr 0x1fc00000, cresp_ready&last with data 0x24010001 two cycles later -> iresp_addr_ok in cycle 0; creq_valid in cycles 1-2 with is_write=0, size=MSIZE4; iresp_data_ok=1 and data 0x24010001 in cycle 2.
- Both requests valid in IDLE: ireq 0x1fc00004 and dreq read 0x00001000 -> dresp_addr_ok first, iresp_addr_ok=0; the fetch is granted in the cycle after dresp_data_ok.
- Byte store: dreq addr 0x00001003, size MSIZE1, strobe 4'b1000, data 0xAAAAAAAA -> creq_is_write=1, strobe=4'b1000, size=MSIZE1; dresp_data_ok when cresp last.
- Reset mid-transaction: reset asserted while in BUSY_D -> creq_valid=0 immediately (asynchronously); no data_ok; the next request after reset is granted normally.
- Timeout with TIMEOUT_CYCLES=8: no cresp for 8 BUSY cycles -> timeout_err=1 and stays set; a later completion still pulses data_ok.
- cresp_ready=1 with cresp_last=0 -> no data_ok and the state stays BUSY; the following ready&last completes the transaction.

Source files
------------

// File: rtl/core_bus_arbiter_pkg.sv
// core_bus_arbiter_pkg: shared types for the core-to-cbus arbiter
package core_bus_arbiter_pkg;
  typedef enum logic [2:0] {MSIZE1 = 3'd0, MSIZE2 = 3'd1, MSIZE4 = 3'd2} msize_t;
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    msize_t      size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;
  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;
  function automatic cbus_req_t fetch_req(input logic [31:0] addr);
    return '{valid: 1'b1, is_write: 1'b0, size: MSIZE4, addr: addr, strobe: 4'b0, data: 32'b0, len: 4'b0};
  endfunction
  function automatic cbus_req_t data_req(input dbus_req_t d);
    return '{valid: 1'b1, is_write: |d.strobe, size: d.size, addr: d.addr, strobe: d.strobe, data: d.data, len: 4'b0};
  endfunction
endpackage

// File: rtl/bus_timeout_counter.sv
// bus_timeout_counter: saturating wait counter with a sticky expiry flag
module bus_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic busy_i,
  output logic expired_o
);
  localparam int W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [W-1:0] cnt_q, cnt_d;
  logic expired_q, expired_d;
  // count stalled busy cycles, saturating; flag latches once the limit is reached
  always_comb begin
    cnt_d = clear_i ? '0 : (busy_i && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    expired_d = expired_q | (TIMEOUT_CYCLES != 0 && cnt_d == W'(TIMEOUT_CYCLES));
  end
  // counter and sticky flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      expired_q <= expired_d;
    end
  end
  assign expired_o = expired_q;
endmodule

// File: rtl/core_bus_arbiter.sv
// core_bus_arbiter: grants ibus/dbus (data first) onto a single-beat cbus, one outstanding
module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [31:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        dreq_valid,
  input  logic [31:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [3:0]  dreq_strobe,
  input  logic [31:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [31:0] dresp_data,
  output logic        creq_valid,
  output logic        creq_is_write,
  output logic [2:0]  creq_size,
  output logic [31:0] creq_addr,
  output logic [3:0]  creq_strobe,
  output logic [31:0] creq_data,
  output logic [3:0]  creq_len,
  input  logic        cresp_ready,
  input  logic        cresp_last,
  input  logic [31:0] cresp_data,
  output logic        timeout_err
);
  arb_state_t state_q, state_d;
  cbus_req_t  req_q, req_d, creq;
  cbus_resp_t cresp;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  logic done, grant, busy;
  assign ireq  = '{valid: ireq_valid, addr: ireq_addr};
  assign dreq  = '{valid: dreq_valid, addr: dreq_addr, size: msize_t'(dreq_size), strobe: dreq_strobe, data: dreq_data};
  assign cresp = '{ready: cresp_ready, last: cresp_last, data: cresp_data};
  assign done  = cresp.ready & cresp.last;
  assign grant = (state_q == IDLE) & (dreq.valid | ireq.valid);
  assign busy  = (state_q != IDLE) & ~done;
  // grant selection, latched request and response steering; everything silent while in reset
  always_comb begin
    state_d = state_q;
    req_d = req_q;
    creq = '0;
    iresp = '0;
    dresp = '0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          dresp.addr_ok = dreq.valid;
          iresp.addr_ok = ireq.valid & ~dreq.valid;
          state_d = dreq.valid ? BUSY_D : ireq.valid ? BUSY_I : IDLE;
          req_d = dreq.valid ? data_req(dreq) : fetch_req(ireq.addr);
        end
        BUSY_I: begin
          creq = req_q;
          iresp.data_ok = done;
          iresp.data = done ? cresp.data : '0;
          state_d = done ? IDLE : BUSY_I;
        end
        BUSY_D: begin
          creq = req_q;
          dresp.data_ok = done;
          dresp.data = done ? cresp.data : '0;
          state_d = done ? IDLE : BUSY_D;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // state and latched request registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q <= '0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
    end
  end
  bus_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (grant),
    .busy_i    (busy),
    .expired_o (timeout_err)
  );
  assign iresp_addr_ok = iresp.addr_ok;
  assign iresp_data_ok = iresp.data_ok;
  assign iresp_data    = iresp.data;
  assign dresp_addr_ok = dresp.addr_ok;
  assign dresp_data_ok = dresp.data_ok;
  assign dresp_data    = dresp.data;
  assign creq_valid    = creq.valid;
  assign creq_is_write = creq.is_write;
  assign creq_size     = creq.size;
  assign creq_addr     = creq.addr;
  assign creq_strobe   = creq.strobe;
  assign creq_data     = creq.data;
  assign creq_len      = creq.len;
endmodule

// File: tb/tb_core_bus_arbiter.sv
// tb_core_bus_arbiter: directed self-checking bench for core_bus_arbiter
module tb_core_bus_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_addr_ok, iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [31:0] dresp_data;
  logic        creq_valid, creq_is_write;
  logic [2:0]  creq_size;
  logic [31:0] creq_addr;
  logic [3:0]  creq_strobe;
  logic [31:0] creq_data;
  logic [3:0]  creq_len;
  logic        cresp_ready, cresp_last;
  logic [31:0] cresp_data;
  logic        timeout_err;
  int checks = 0;
  int errors = 0;

  core_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_addr_ok(iresp_addr_ok), .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_size(creq_size),
    .creq_addr(creq_addr), .creq_strobe(creq_strobe), .creq_data(creq_data), .creq_len(creq_len),
    .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    ireq_valid = 0; ireq_addr = 0;
    dreq_valid = 0; dreq_addr = 0; dreq_size = 0; dreq_strobe = 0; dreq_data = 0;
    cresp_ready = 0; cresp_last = 0; cresp_data = 0;
  endtask

  task automatic resp(input logic rdy, input logic lst, input logic [31:0] d);
    cresp_ready = rdy; cresp_last = lst; cresp_data = d;
  endtask

  task automatic dreq(input logic [31:0] a, input logic [2:0] s, input logic [3:0] st, input logic [31:0] d);
    dreq_valid = 1; dreq_addr = a; dreq_size = s; dreq_strobe = st; dreq_data = d;
  endtask

  initial begin
    reset = 1;
    idle_in();
    ireq_valid = 1; ireq_addr = 32'h1fc00000;
    dreq(32'h1000, 3'd2, 4'h0, 32'h0);
    #1;
    chk("rst_iaddr_ok", 32'(iresp_addr_ok), 0);
    chk("rst_daddr_ok", 32'(dresp_addr_ok), 0);
    chk("rst_creq_valid", 32'(creq_valid), 0);
    chk("rst_timeout", 32'(timeout_err), 0);
    @(negedge clk); @(negedge clk);
    reset = 0; idle_in();
    // single fetch
    ireq_valid = 1; ireq_addr = 32'h1fc00000;
    #1;
    chk("f0_addr_ok", 32'(iresp_addr_ok), 1);
    chk("f0_creq_valid", 32'(creq_valid), 0);
    @(negedge clk); ireq_valid = 0; #1;
    chk("f1_creq_valid", 32'(creq_valid), 1);
    chk("f1_is_write", 32'(creq_is_write), 0);
    chk("f1_size", 32'(creq_size), 2);
    chk("f1_addr", creq_addr, 32'h1fc00000);
    chk("f1_len", 32'(creq_len), 0);
    chk("f1_data_ok", 32'(iresp_data_ok), 0);
    @(negedge clk); resp(1, 1, 32'h24010001); #1;
    chk("f2_creq_valid", 32'(creq_valid), 1);
    chk("f2_data_ok", 32'(iresp_data_ok), 1);
    chk("f2_data", iresp_data, 32'h24010001);
    chk("f2_d_data_ok", 32'(dresp_data_ok), 0);
    @(negedge clk); resp(0, 0, 32'h24010001); #1;
    chk("f3_creq_valid", 32'(creq_valid), 0);
    chk("f3_data_ok", 32'(iresp_data_ok), 0);
    chk("f3_data", iresp_data, 0);
    // both valid: data wins, fetch granted after dresp_data_ok
    @(negedge clk);
    ireq_valid = 1; ireq_addr = 32'h1fc00004;
    dreq(32'h00001000, 3'd2, 4'h0, 32'h0);
    #1;
    chk("b0_daddr_ok", 32'(dresp_addr_ok), 1);
    chk("b0_iaddr_ok", 32'(iresp_addr_ok), 0);
    @(negedge clk); dreq_valid = 0; resp(1, 1, 32'h00000055); #1;
    chk("b1_addr", creq_addr, 32'h00001000);
    chk("b1_is_write", 32'(creq_is_write), 0);
    chk("b1_iaddr_ok", 32'(iresp_addr_ok), 0);
    chk("b1_d_data_ok", 32'(dresp_data_ok), 1);
    chk("b1_d_data", dresp_data, 32'h55);
    @(negedge clk); resp(0, 0, 0); #1;
    chk("b2_iaddr_ok", 32'(iresp_addr_ok), 1);
    chk("b2_d_data_ok", 32'(dresp_data_ok), 0);
    @(negedge clk); ireq_valid = 0; resp(1, 1, 32'h11); #1;
    chk("b3_addr", creq_addr, 32'h1fc00004);
    chk("b3_i_data_ok", 32'(iresp_data_ok), 1);
    chk("b3_i_data", iresp_data, 32'h11);
    // byte store with a ready-without-last beat in the middle
    @(negedge clk); resp(0, 0, 0);
    dreq(32'h00001003, 3'd0, 4'b1000, 32'hAAAAAAAA);
    #1;
    chk("s0_daddr_ok", 32'(dresp_addr_ok), 1);
    @(negedge clk); dreq_valid = 0; resp(1, 0, 32'hdead0000); #1;
    chk("s1_is_write", 32'(creq_is_write), 1);
    chk("s1_strobe", 32'(creq_strobe), 32'b1000);
    chk("s1_size", 32'(creq_size), 0);
    chk("s1_addr", creq_addr, 32'h00001003);
    chk("s1_data", creq_data, 32'hAAAAAAAA);
    chk("s1_noload_ok", 32'(dresp_data_ok), 0);
    chk("s1_noload_data", dresp_data, 0);
    @(negedge clk); resp(0, 0, 0); #1;
    chk("s2_still_busy", 32'(creq_valid), 1);
    @(negedge clk); resp(1, 1, 32'hAAAAAAAA); #1;
    chk("s3_d_data_ok", 32'(dresp_data_ok), 1);
    chk("s3_d_data", dresp_data, 32'hAAAAAAAA);
    @(negedge clk); resp(0, 0, 0); #1;
    chk("s4_creq_valid", 32'(creq_valid), 0);
    chk("s4_strobe", 32'(creq_strobe), 0);
    chk("s4_timeout", 32'(timeout_err), 0);
    // reset mid-transaction
    @(negedge clk); dreq(32'h2000, 3'd2, 4'h0, 0); #1;
    chk("r0_daddr_ok", 32'(dresp_addr_ok), 1);
    @(negedge clk); dreq_valid = 0; #1;
    chk("r1_creq_valid", 32'(creq_valid), 1);
    #2; reset = 1; resp(1, 1, 32'h77); #1;
    chk("r1_async_valid", 32'(creq_valid), 0);
    chk("r1_async_ok", 32'(dresp_data_ok), 0);
    @(negedge clk); reset = 0; resp(0, 0, 0);
    ireq_valid = 1; ireq_addr = 32'h1fc00008; #1;
    chk("r2_iaddr_ok", 32'(iresp_addr_ok), 1);
    @(negedge clk); ireq_valid = 0; resp(1, 1, 32'h99); #1;
    chk("r3_addr", creq_addr, 32'h1fc00008);
    chk("r3_i_data_ok", 32'(iresp_data_ok), 1);
    // timeout after 8 stalled busy cycles
    @(negedge clk); resp(0, 0, 0); dreq(32'h3000, 3'd2, 4'h0, 0); #1;
    chk("t0_daddr_ok", 32'(dresp_addr_ok), 1);
    @(negedge clk); dreq_valid = 0;
    for (int i = 0; i < 7; i++) @(negedge clk);
    #1;
    chk("t8_timeout_clear", 32'(timeout_err), 0);
    @(negedge clk); #1;
    chk("t9_timeout_set", 32'(timeout_err), 1);
    chk("t9_still_busy", 32'(creq_valid), 1);
    @(negedge clk); resp(1, 1, 32'hcafe); #1;
    chk("t10_d_data_ok", 32'(dresp_data_ok), 1);
    chk("t10_d_data", dresp_data, 32'hcafe);
    @(negedge clk); resp(0, 0, 0); #1;
    chk("t11_timeout_sticky", 32'(timeout_err), 1);
    chk("t11_idle", 32'(creq_valid), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
